// File: rtl/uart_pkg.sv
// Shared types for the configurable UART receiver: parity modes, receiver FSM states
// and the packed word that carries received data plus its status flags.
package uart_pkg;

   localparam int UART_MAX_BITS = 9;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HI
   } rx_state_t;

   typedef struct packed {
      logic [UART_MAX_BITS-1:0] data;
      logic                     frame_err;
      logic                     parity_err;
      logic                     brk;
   } rx_word_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO of received words; head entry is visible whenever not empty.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  rx_word_t push_word,
   input  logic     pop,
   output rx_word_t head_word,
   output logic     empty,
   output logic     full
);

   localparam int AW = $clog2(DEPTH);

   rx_word_t       mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q;
   logic [AW-1:0]  rd_ptr_q;
   logic [AW:0]    count_q;

   assign empty     = (count_q == '0);
   assign full      = (count_q == (AW+1)'(DEPTH));
   assign head_word = mem_q[rd_ptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_word;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with valid/ready output.
// UART_RX_FIFO_EN selects a receive FIFO instead of the single holding register.
//
// state      | meaning
// IDLE       | line idle, waiting for falling edge
// START      | half-bit wait, confirm start bit still low
// DATA       | sampling data bits LSB first, one per bit period
// PARITY     | sampling the parity bit
// STOP       | sampling one or two stop bits
// WAIT_HI    | framing error seen, wait for line to return high
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int PAYLOAD_BITS = 8,
   parameter int DIV_W        = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    uart_rxd,
   input  logic                    uart_rx_en,
   input  logic [DIV_W-1:0]        cfg_div,
   input  logic [3:0]              cfg_bits,
   input  logic [1:0]              cfg_parity,
   input  logic                    cfg_stop2,
   output logic                    rx_valid,
   input  logic                    rx_ready,
   output logic [PAYLOAD_BITS-1:0] rx_data,
   output logic                    rx_frame_err,
   output logic                    rx_parity_err,
   output logic                    rx_break,
   output logic                    rx_overrun
);

   logic [1:0]              sync_q;
   logic                    rxd_s;
   rx_state_t               state_q, state_d;
   logic [DIV_W-1:0]        cnt_q;
   logic [3:0]              bit_cnt_q;
   logic                    stop_idx_q;
   logic [PAYLOAD_BITS-1:0] data_q;
   logic                    any_one_q, parity_err_q, frame_err_q, done_q;
   logic                    start_frame, load_full, smp_data, smp_par, smp_stop, frame_done;
   logic                    tick, par_en;
   rx_word_t                word_d, out_word;
   logic                    overrun_q;

   assign rxd_s  = sync_q[1];
   assign tick   = (cnt_q == '0);
   assign par_en = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              sync_q <= 2'b11;
      else if (!uart_rx_en) sync_q <= 2'b11;
      else                  sync_q <= {sync_q[0], uart_rxd};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      start_frame = 1'b0;
      load_full   = 1'b0;
      smp_data    = 1'b0;
      smp_par     = 1'b0;
      smp_stop    = 1'b0;
      frame_done  = 1'b0;
      if (!uart_rx_en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (!rxd_s) begin
               state_d     = ST_START;
               start_frame = 1'b1;
            end
            ST_START: if (tick) begin
               if (rxd_s) state_d = ST_IDLE;
               else begin
                  state_d   = ST_DATA;
                  load_full = 1'b1;
               end
            end
            ST_DATA: if (tick) begin
               smp_data  = 1'b1;
               load_full = 1'b1;
               if (bit_cnt_q == cfg_bits - 4'd1) state_d = par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (tick) begin
               smp_par   = 1'b1;
               load_full = 1'b1;
               state_d   = ST_STOP;
            end
            ST_STOP: if (tick) begin
               smp_stop  = 1'b1;
               load_full = 1'b1;
               if (!cfg_stop2 || stop_idx_q) begin
                  frame_done = 1'b1;
                  state_d    = (frame_err_q || !rxd_s) ? ST_WAIT_HI : ST_IDLE;
               end
            end
            ST_WAIT_HI: if (rxd_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Bit timer counts down to a terminal zero; reload value picks mid-bit sampling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (start_frame) begin
         cnt_q <= (cfg_div >> 1) - DIV_W'(1);
      end else if (load_full) begin
         cnt_q <= cfg_div - DIV_W'(1);
      end else if (!tick) begin
         cnt_q <= cnt_q - DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q    <= '0;
         stop_idx_q   <= 1'b0;
         data_q       <= '0;
         any_one_q    <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= frame_done;
         if (start_frame) begin
            bit_cnt_q    <= '0;
            stop_idx_q   <= 1'b0;
            data_q       <= '0;
            any_one_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
         end
         if (smp_data) begin
            for (int i = 0; i < PAYLOAD_BITS; i++)
               if (bit_cnt_q == 4'(i)) data_q[i] <= rxd_s;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (rxd_s) any_one_q <= 1'b1;
         end
         if (smp_par) begin
            if (rxd_s) any_one_q <= 1'b1;
            if (cfg_parity == PAR_EVEN) parity_err_q <= (^data_q) ^ rxd_s;
            else                        parity_err_q <= ~((^data_q) ^ rxd_s);
         end
         if (smp_stop) begin
            stop_idx_q <= 1'b1;
            if (!rxd_s) frame_err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      word_d                         = '0;
      word_d.data[PAYLOAD_BITS-1:0]  = data_q;
      word_d.frame_err               = frame_err_q;
      word_d.parity_err              = parity_err_q;
      word_d.brk                     = frame_err_q && !any_one_q;
   end

`ifdef UART_RX_FIFO_EN
   logic fifo_empty, fifo_full, fifo_push, fifo_pop;

   assign fifo_pop  = rx_ready && !fifo_empty;
   assign fifo_push = done_q && (!fifo_full || fifo_pop);
   assign rx_valid  = !fifo_empty;

   uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_word (word_d),
      .pop       (fifo_pop),
      .head_word (out_word),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) overrun_q <= 1'b0;
      else     overrun_q <= done_q && !fifo_push;
   end
`else
   logic hold_valid_q;

   assign rx_valid = hold_valid_q;

   // A word being read this cycle frees the register for the completing word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_word     <= '0;
         hold_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (done_q) begin
            if (!hold_valid_q || rx_ready) begin
               out_word     <= word_d;
               hold_valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (rx_ready) begin
            hold_valid_q <= 1'b0;
         end
      end
   end
`endif

   logic unused_hi;
   assign unused_hi = ^(out_word.data >> PAYLOAD_BITS);

   assign rx_data       = out_word.data[PAYLOAD_BITS-1:0];
   assign rx_frame_err  = out_word.frame_err;
   assign rx_parity_err = out_word.parity_err;
   assign rx_break      = out_word.brk;
   assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: table of frame formats plus break, glitch,
// overrun and mid-frame abort sequences.
module tb_uart_rx_cfg;

   logic        clk = 1'b0;
   logic        rst;
   logic        uart_rxd;
   logic        uart_rx_en;
   logic [15:0] cfg_div;
   logic [3:0]  cfg_bits;
   logic [1:0]  cfg_parity;
   logic        cfg_stop2;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  rx_data;
   logic        rx_frame_err;
   logic        rx_parity_err;
   logic        rx_break;
   logic        rx_overrun;

   int total = 0;
   int bad   = 0;

`ifdef UART_RX_FIFO_EN
   localparam int N_OVR = 5;
`else
   localparam int N_OVR = 2;
`endif

   uart_rx_cfg dut (
      .clk           (clk),
      .rst           (rst),
      .uart_rxd      (uart_rxd),
      .uart_rx_en    (uart_rx_en),
      .cfg_div       (cfg_div),
      .cfg_bits      (cfg_bits),
      .cfg_parity    (cfg_parity),
      .cfg_stop2     (cfg_stop2),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_data       (rx_data),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err),
      .rx_break      (rx_break),
      .rx_overrun    (rx_overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
      logic       brk;
   } cap_t;

   cap_t cap_q[$];
   int   ovr_cnt = 0;
   int   rd_idx  = 0;

   always @(negedge clk) begin
      if (rx_valid && rx_ready) cap_q.push_back('{rx_data, rx_frame_err, rx_parity_err, rx_break});
      if (rx_overrun) ovr_cnt++;
   end

   typedef struct {
      int         div;
      int         bits;
      logic [1:0] par;
      logic       stop2;
      logic [8:0] data;
      logic       bad_par;
      logic [1:0] stop_bad;
      logic [7:0] exp_data;
      logic       exp_fe;
      logic       exp_pe;
      logic       exp_brk;
   } vec_t;

   vec_t vecs[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b, input int div);
      uart_rxd = b;
      repeat (div) tick();
   endtask

   task automatic send_frame(input int div, input int bits, input logic [8:0] data,
                             input logic [1:0] par, input logic bad_par,
                             input logic stop2, input logic [1:0] stop_bad);
      logic p;
      p = 1'b0;
      send_bit(1'b0, div);
      for (int i = 0; i < bits; i++) begin
         send_bit(data[i], div);
         p = p ^ data[i];
      end
      if (par == 2'd1 || par == 2'd2) send_bit(p ^ (par == 2'd2) ^ bad_par, div);
      send_bit(!stop_bad[0], div);
      if (stop2) send_bit(!stop_bad[1], div);
      send_bit(1'b1, 3 * div);
   endtask

   task automatic configure(input int div, input int bits, input logic [1:0] par, input logic stop2);
      uart_rx_en = 1'b0;
      tick();
      cfg_div    = 16'(div);
      cfg_bits   = 4'(bits);
      cfg_parity = par;
      cfg_stop2  = stop2;
      uart_rx_en = 1'b1;
      repeat (4) tick();
   endtask

   task automatic expect_word(input string name, input logic [7:0] d, input logic fe,
                              input logic pe, input logic brk);
      cap_t w;
      check({name, ".count"}, 32'(cap_q.size() - rd_idx), 32'd1);
      if (cap_q.size() > rd_idx) begin
         w = cap_q[rd_idx];
         rd_idx++;
         check({name, ".data"}, 32'(w.d),   32'(d));
         check({name, ".fe"},   32'(w.fe),  32'(fe));
         check({name, ".pe"},   32'(w.pe),  32'(pe));
         check({name, ".brk"},  32'(w.brk), 32'(brk));
      end
      rd_idx = cap_q.size();
   endtask

   initial begin
      //          div bits par  s2   data    badp  stopbad  exp   fe    pe    brk
      vecs[0]  = '{8,  8, 2'd0, 1'b0, 9'h0A5, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{16, 7, 2'd1, 1'b1, 9'h03C, 1'b1, 2'b00, 8'h3C, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{16, 7, 2'd1, 1'b1, 9'h03C, 1'b0, 2'b00, 8'h3C, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{8,  8, 2'd2, 1'b0, 9'h000, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{8,  5, 2'd0, 1'b0, 9'h01F, 1'b0, 2'b00, 8'h1F, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{8,  5, 2'd3, 1'b0, 9'h0F6, 1'b0, 2'b00, 8'h16, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{10, 8, 2'd0, 1'b1, 9'h081, 1'b0, 2'b10, 8'h81, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{8,  8, 2'd1, 1'b0, 9'h001, 1'b0, 2'b00, 8'h01, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{8,  8, 2'd0, 1'b0, 9'h05A, 1'b0, 2'b01, 8'h5A, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{12, 6, 2'd2, 1'b0, 9'h02A, 1'b1, 2'b00, 8'h2A, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{8,  8, 2'd1, 1'b0, 9'h000, 1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b1};

      rst        = 1'b1;
      uart_rxd   = 1'b1;
      uart_rx_en = 1'b0;
      rx_ready   = 1'b1;
      cfg_div    = 16'd8;
      cfg_bits   = 4'd8;
      cfg_parity = 2'd0;
      cfg_stop2  = 1'b0;
      repeat (3) tick();
      check("reset.valid",   32'(rx_valid),      32'd0);
      check("reset.data",    32'(rx_data),       32'd0);
      check("reset.fe",      32'(rx_frame_err),  32'd0);
      check("reset.pe",      32'(rx_parity_err), 32'd0);
      check("reset.brk",     32'(rx_break),      32'd0);
      check("reset.overrun", 32'(rx_overrun),    32'd0);
      rst = 1'b0;
      tick();

      for (int v = 0; v < 11; v++) begin
         configure(vecs[v].div, vecs[v].bits, vecs[v].par, vecs[v].stop2);
         send_frame(vecs[v].div, vecs[v].bits, vecs[v].data, vecs[v].par,
                    vecs[v].bad_par, vecs[v].stop2, vecs[v].stop_bad);
         expect_word($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_fe,
                     vecs[v].exp_pe, vecs[v].exp_brk);
      end

      // Held break: one word only, no retrigger while the line stays low.
      configure(8, 8, 2'd0, 1'b0);
      send_bit(1'b0, 12 * 8);
      send_bit(1'b1, 20 * 8);
      expect_word("break", 8'h00, 1'b1, 1'b0, 1'b1);
      send_frame(8, 8, 9'h033, 2'd0, 1'b0, 1'b0, 2'b00);
      expect_word("after_break", 8'h33, 1'b0, 1'b0, 1'b0);

      // Two-cycle glitch on an idle line must not produce a word.
      send_bit(1'b0, 2);
      send_bit(1'b1, 6 * 8);
      check("glitch.count", 32'(cap_q.size() - rd_idx), 32'd0);

      // Overrun: consumer stalled, last word dropped.
      begin
         int ovr0;
         ovr0     = ovr_cnt;
         rx_ready = 1'b0;
         for (int k = 0; k < N_OVR; k++)
            send_frame(8, 8, (k == N_OVR - 1) ? 9'h099 : 9'(8'h11 * (k + 1)), 2'd0, 1'b0, 1'b0, 2'b00);
         check("ovr.pulses", 32'(ovr_cnt - ovr0), 32'd1);
         check("ovr.valid_held", 32'(rx_valid), 32'd1);
         check("ovr.data_held",  32'(rx_data),  32'h11);
         rx_ready = 1'b1;
         repeat (N_OVR + 4) tick();
         check("ovr.count", 32'(cap_q.size() - rd_idx), 32'(N_OVR - 1));
         for (int k = 0; k < N_OVR - 1; k++)
            if (cap_q.size() > rd_idx + k)
               check($sformatf("ovr.word%0d", k), 32'(cap_q[rd_idx + k].d), 32'(8'h11 * (k + 1)));
         rd_idx = cap_q.size();
      end

      // Reset mid-frame at bit 4, then a clean frame.
      configure(8, 8, 2'd0, 1'b0);
      send_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 8);
      rst = 1'b1;
      repeat (2) tick();
      rst      = 1'b0;
      uart_rxd = 1'b1;
      repeat (20 * 8) tick();
      check("rst_abort.count", 32'(cap_q.size() - rd_idx), 32'd0);
      send_frame(8, 8, 9'h05A, 2'd0, 1'b0, 1'b0, 2'b00);
      expect_word("rst_abort.next", 8'h5A, 1'b0, 1'b0, 1'b0);

      // Enable dropped mid-frame at bit 4, then a clean frame.
      send_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 8);
      uart_rx_en = 1'b0;
      repeat (2) tick();
      uart_rx_en = 1'b1;
      uart_rxd   = 1'b1;
      repeat (20 * 8) tick();
      check("en_abort.count", 32'(cap_q.size() - rd_idx), 32'd0);
      send_frame(8, 8, 9'h05A, 2'd0, 1'b0, 1'b0, 2'b00);
      expect_word("en_abort.next", 8'h5A, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
